traffic_sequencer: RTL
======================

# traffic_sequencer

Timed phase sequencer that generates the 2-bit light code consumed by the `trafficlight` decoder, which turns it into the 3-bit lamp value. It walks a safe all-red startup phase, then cycles GREEN → YELLOW → RED with per-phase dwell counters. A latched pedestrian request shortens GREEN once its minimum time has elapsed. It sits between the board-level clock/button logic and `trafficlight`; its `light_code` output connects directly to the decoder's controller input.

## Interface
- `START_CYCLES`, 4: all-red dwell after reset.
- `GREEN_MIN`, 8: minimum GREEN dwell before a pedestrian request may end it.
- `GREEN_MAX`, 32: GREEN dwell with no request.
- `YELLOW_CYCLES`, 3: YELLOW dwell.
- `RED_CYCLES`, 6: RED dwell.
- `CNT_W`, 8: dwell counter width. Every dwell parameter is ≥1 and ≤ 2^CNT_W; `GREEN_MIN` ≤ `GREEN_MAX`.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable; 0 freezes the state and the counter.
- `ped_req`  in  1  pedestrian button, synchronous level, sampled every cycle.
- `light_code`  out  2  decoder code: 00 ALL_RED, 01 GREEN, 10 YELLOW, 11 RED.
- `ped_walk`  out  1  high while in RED.
- `ped_ack`  out  1  one-cycle pulse when a pending request is served.

## Operation
- States: STARTUP, GREEN, YELLOW, RED. `light_code` is 00 only in STARTUP.
- Dwell counter `cnt` is 0 on the first cycle of each state and increments each cycle that `en`=1.
- A state with dwell N exits at the clock edge where `cnt`==N-1 and `en`=1.
- STARTUP→GREEN after `START_CYCLES`. YELLOW→RED after `YELLOW_CYCLES`. RED→GREEN after `RED_CYCLES`.
- GREEN→YELLOW at the first enabled edge where either condition holds:
  - `cnt`==GREEN_MAX-1, or
  - `ped_pending`=1 and `cnt`≥GREEN_MIN-1.
- `ped_pending` is set by `ped_req`=1 in any state except RED, regardless of `en`. It clears on the edge entering RED.
- `ped_req` during RED is ignored (walk is already active).
- `ped_ack` pulses for exactly the first cycle of RED when `ped_pending` was set at entry. RED entered without a pending request gives no pulse.
- Simultaneous `ped_req` and the edge entering RED: the request is consumed by that RED; no second pending request.
- `en`=0 holds all outputs. An `ped_ack` already high stays high until the next enabled cycle.
- Counter never wraps: every dwell ends at its terminal count.

## Timing
- All outputs are registered.
- A state change is visible on `light_code` and `ped_walk` the cycle after the exit edge.
- Reset asserted, asynchronously: state STARTUP, `cnt`=0, `ped_pending`=0, `light_code`=00, `ped_walk`=0, `ped_acknowledged`-path `ped_ack`=0.
- Reset mid-phase abandons that phase immediately, with no YELLOW transition.
- After `rst_n` deasserts with `en`=1 held, GREEN appears on `light_code` after exactly `START_CYCLES` clock edges.
- Full cycle without requests: GREEN_MAX + YELLOW_CYCLES + RED_CYCLES cycles (41 with defaults).
- Minimum request-to-walk latency from GREEN cycle 0: GREEN_MIN + YELLOW_CYCLES cycles.

## Structure
- `traffic_pkg` holds:
  - the state enum;
  - light-code constants LC_ALL_RED/LC_GREEN/LC_YELLOW/LC_RED, shared with `trafficlight` and benches.
- Sub-module `phase_timer`:
  - inputs: clear, enable, terminal value;
  - output: `done` combinational compare of `cnt`==terminal-1.
- The top holds the FSM, `ped_pending` and the output registers.

## Test plan
- Reset, then `en`=1, no requests → `light_code` 00 for 4 cycles, then 01 for 32, 10 for 3, 11 for 6 (`ped_walk`=1), then 01. `ped_ack` never pulses.
- `ped_req` pulsed at GREEN cnt=2 → YELLOW begins after GREEN cnt=7 (8 GREEN cycles). `ped_ack`=1 for the first RED cycle only.
- `ped_req` at GREEN cnt=20 (past minimum) → next edge goes YELLOW. GREEN lasts 21 cycles.
- `ped_req` held high through YELLOW and RED → one `ped_ack`. The next GREEN runs 32 cycles unless `ped_req` is asserted again in GREEN.
- `en` dropped for 5 cycles at YELLOW cnt=1 → `light_code` holds 10. YELLOW totals 3 enabled cycles; RED dwell unaffected.
- `rst_n` pulsed low mid-RED → `light_code`=00 and `ped_walk`=0 immediately, with no clock. The sequence restarts with 4 STARTUP cycles.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and light-code constants for the traffic sequencer and its consumers.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_RED     = 2'd3
  } state_t;

  localparam logic [1:0] LC_ALL_RED = 2'b00;
  localparam logic [1:0] LC_GREEN   = 2'b01;
  localparam logic [1:0] LC_YELLOW  = 2'b10;
  localparam logic [1:0] LC_RED     = 2'b11;

  function automatic logic [1:0] light_code_of(input state_t s);
    logic [1:0] lc;
    case (s)
      ST_GREEN:  lc = LC_GREEN;
      ST_YELLOW: lc = LC_YELLOW;
      ST_RED:    lc = LC_RED;
      default:   lc = LC_ALL_RED;
    endcase
    return lc;
  endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// Control/status bundle between board logic (master) and the sequencer (slave).
interface traffic_sequencer_if;
  import traffic_pkg::*;

  // No handshake: en qualifies every advance; outputs are registered and hold while en=0.
  logic       en;
  logic       ped_req;
  logic [1:0] light_code;
  logic       ped_walk;
  logic       ped_ack;
  state_t     dbg_state;

  modport master (output en, ped_req, input light_code, ped_walk, ped_ack, dbg_state);
  modport slave  (input en, ped_req, output light_code, ped_walk, ped_ack, dbg_state);

endinterface

// File: rtl/phase_timer.sv
// Per-phase dwell counter; done flags the terminal count of the current phase.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W:0]   i_terminal,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_last;

  // One extra bit lets a dwell of exactly 2^CNT_W be expressed.
  assign w_last = i_terminal - (CNT_W+1)'(1);
  assign o_done = ({1'b0, r_cnt} == w_last);
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Timed STARTUP/GREEN/YELLOW/RED sequencer driving the trafficlight decoder code,
// with a latched pedestrian request that can cut GREEN short after its minimum.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int START_CYCLES  = 4,
  parameter int GREEN_MIN     = 8,
  parameter int GREEN_MAX     = 32,
  parameter int YELLOW_CYCLES = 3,
  parameter int RED_CYCLES    = 6,
  parameter int CNT_W         = 8
) (
  input logic               clk,
  input logic               rst_n,
  traffic_sequencer_if.slave bus
);

  localparam logic [CNT_W:0] T_START     = (CNT_W+1)'(START_CYCLES);
  localparam logic [CNT_W:0] T_GREEN     = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0] T_YELLOW    = (CNT_W+1)'(YELLOW_CYCLES);
  localparam logic [CNT_W:0] T_RED       = (CNT_W+1)'(RED_CYCLES);
  localparam logic [CNT_W:0] GREEN_MIN_L = (CNT_W+1)'(GREEN_MIN - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W:0]   w_terminal;
  logic [CNT_W-1:0] w_cnt;
  logic             w_done;
  logic             w_min_ok;
  logic             w_ped_eff;
  logic             w_exit;
  logic             w_enter_red;
  logic             r_ped_pending;
  logic [1:0]       r_light_code;
  logic [1:0]       w_light_code_d;
  logic             r_ped_walk;
  logic             w_ped_walk_d;
  logic             r_ped_ack;
  logic             w_ped_ack_d;

  always_comb begin
    w_terminal = T_START;
    case (r_state)
      ST_GREEN:  w_terminal = T_GREEN;
      ST_YELLOW: w_terminal = T_YELLOW;
      ST_RED:    w_terminal = T_RED;
      default:   w_terminal = T_START;
    endcase
  end

  // A request arriving on the same cycle counts, so GREEN can end on that very edge.
  assign w_min_ok    = ({1'b0, w_cnt} >= GREEN_MIN_L);
  assign w_ped_eff   = r_ped_pending | (bus.ped_req & (r_state != ST_RED));
  assign w_exit      = bus.en & (w_done | ((r_state == ST_GREEN) & w_ped_eff & w_min_ok));
  assign w_enter_red = w_exit & (r_state == ST_YELLOW);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (w_exit),
    .i_enable   (bus.en),
    .i_terminal (w_terminal),
    .o_cnt      (w_cnt),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_STARTUP;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_exit) begin
      case (r_state)
        ST_STARTUP: w_next_state = ST_GREEN;
        ST_GREEN:   w_next_state = ST_YELLOW;
        ST_YELLOW:  w_next_state = ST_RED;
        default:    w_next_state = ST_GREEN;
      endcase
    end
  end

  always_comb begin
    w_light_code_d = light_code_of(w_next_state);
    w_ped_walk_d   = (w_next_state == ST_RED);
    w_ped_ack_d    = w_enter_red & w_ped_eff;
  end

  // Output registers only move on enabled cycles, which keeps a raised ack held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_light_code <= LC_ALL_RED;
      r_ped_walk   <= 1'b0;
      r_ped_ack    <= 1'b0;
    end else if (bus.en) begin
      r_light_code <= w_light_code_d;
      r_ped_walk   <= w_ped_walk_d;
      r_ped_ack    <= w_ped_ack_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped_pending <= 1'b0;
    end else if (w_enter_red) begin
      r_ped_pending <= 1'b0;
    end else if (bus.ped_req && (r_state != ST_RED)) begin
      r_ped_pending <= 1'b1;
    end
  end

  assign bus.light_code = r_light_code;
  assign bus.ped_walk   = r_ped_walk;
  assign bus.ped_ack    = r_ped_ack;
  assign bus.dbg_state  = r_state;

endmodule
